// File: rtl/dma_desc_mem_arbiter.sv
// Shares one AVMM descriptor-memory port between the SG-DMA fetch (burst read) and
// status-update (single write) masters. Build option: DMA_ARB_FIXED_PRIO_EN (write wins ties).
//
// state   | meaning
// IDLE    | sample both requests and pick a winner
// RD_CMD  | fetch burst command presented to memory
// RD_DATA | forward read words until the burst drains; no commands issued
// WR_CMD  | update write presented to memory

module dma_desc_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int BCOUNT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_read_i,
  input  logic [BCOUNT_W-1:0] fetch_bcount_i,
  input  logic [ADDR_W-1:0]   fetch_addr_i,
  output logic                fetch_waitrequest_o,
  output logic [31:0]         fetch_rddata_o,
  output logic                fetch_readdatavalid_o,
  input  logic                update_wr_i,
  input  logic [31:0]         update_data_i,
  input  logic [3:0]          update_be_i,
  input  logic [ADDR_W-1:0]   update_addr_i,
  output logic                update_wait_req_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [BCOUNT_W-1:0] mem_bcount_o,
  output logic [31:0]         mem_wrdata_o,
  output logic [3:0]          mem_be_o,
  input  logic                mem_waitrequest_i,
  input  logic [31:0]         mem_rddata_i,
  input  logic                mem_readdatavalid_i,
  output logic                err_unexp_rdv_o
);

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR_CMD} state_t;

  state_t              state, state_nxt;
  logic [BCOUNT_W:0]   rd_remaining, rd_remaining_nxt;
  logic                last_was_wr, last_was_wr_nxt;
  logic                err_unexp_rdv_nxt;
  logic [BCOUNT_W-1:0] rd_len;
  logic                tie_goes_wr;

  // A zero-length burst is treated as a single word on the bus and in the counter.
  assign rd_len = (fetch_bcount_i == '0) ? BCOUNT_W'(1) : fetch_bcount_i;

`ifdef DMA_ARB_FIXED_PRIO_EN
  assign tie_goes_wr = 1'b1;
`else
  assign tie_goes_wr = !last_was_wr;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rd_remaining    <= '0;
      last_was_wr     <= 1'b0;
      err_unexp_rdv_o <= 1'b0;
    end else begin
      state           <= state_nxt;
      rd_remaining    <= rd_remaining_nxt;
      last_was_wr     <= last_was_wr_nxt;
      err_unexp_rdv_o <= err_unexp_rdv_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    rd_remaining_nxt  = rd_remaining;
    last_was_wr_nxt   = last_was_wr;
    err_unexp_rdv_nxt = err_unexp_rdv_o | (mem_readdatavalid_i && (state != RD_DATA));
    case (state)
      IDLE: begin
        if (fetch_read_i && update_wr_i) begin
          state_nxt       = tie_goes_wr ? WR_CMD : RD_CMD;
          last_was_wr_nxt = tie_goes_wr;
        end else if (fetch_read_i) begin
          state_nxt       = RD_CMD;
          last_was_wr_nxt = 1'b0;
        end else if (update_wr_i) begin
          state_nxt       = WR_CMD;
          last_was_wr_nxt = 1'b1;
        end
      end
      RD_CMD: begin
        if (!mem_waitrequest_i) begin
          rd_remaining_nxt = {1'b0, rd_len};
          state_nxt        = RD_DATA;
        end
      end
      RD_DATA: begin
        if (mem_readdatavalid_i) begin
          rd_remaining_nxt = rd_remaining - (BCOUNT_W+1)'(1);
          if (rd_remaining == (BCOUNT_W+1)'(1)) state_nxt = IDLE;
        end
      end
      WR_CMD: begin
        if (!mem_waitrequest_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fetch_waitrequest_o   = 1'b1;
    update_wait_req_o     = 1'b1;
    fetch_readdatavalid_o = 1'b0;
    mem_read_o            = 1'b0;
    mem_write_o           = 1'b0;
    mem_addr_o            = '0;
    mem_bcount_o          = '0;
    mem_wrdata_o          = '0;
    mem_be_o              = '0;
    case (state)
      RD_CMD: begin
        mem_read_o          = 1'b1;
        mem_addr_o          = fetch_addr_i;
        mem_bcount_o        = rd_len;
        mem_be_o            = 4'hF;
        fetch_waitrequest_o = mem_waitrequest_i;
      end
      RD_DATA: fetch_readdatavalid_o = mem_readdatavalid_i;
      WR_CMD: begin
        mem_write_o       = 1'b1;
        mem_addr_o        = update_addr_i;
        mem_bcount_o      = BCOUNT_W'(1);
        mem_wrdata_o      = update_data_i;
        mem_be_o          = update_be_i;
        update_wait_req_o = mem_waitrequest_i;
      end
      default: ;
    endcase
  end

  assign fetch_rddata_o = mem_rddata_i;

endmodule

// File: tb/tb_dma_desc_mem_arbiter.sv
// Testbench for dma_desc_mem_arbiter: directed scenarios plus a randomized two-master run
// checked against a transaction-level model. Honours DMA_ARB_FIXED_PRIO_EN for tie expectations.

module tb_dma_desc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_read_i;
  logic [3:0]  fetch_bcount_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_waitrequest_o;
  logic [31:0] fetch_rddata_o;
  logic        fetch_readdatavalid_o;
  logic        update_wr_i;
  logic [31:0] update_data_i;
  logic [3:0]  update_be_i;
  logic [31:0] update_addr_i;
  logic        update_wait_req_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_bcount_o;
  logic [31:0] mem_wrdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_waitrequest_i;
  logic [31:0] mem_rddata_i;
  logic        mem_readdatavalid_i;
  logic        err_unexp_rdv_o;

  int checks = 0;
  int errors = 0;

  typedef struct {logic [31:0] addr; logic [3:0] bcount;} rd_req_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] be;} wr_req_t;
  rd_req_t rd_q[$];
  wr_req_t wr_q[$];
  bit      grant_log[$];  // 1 = write granted, 0 = read granted

  dma_desc_mem_arbiter #(.ADDR_W(32), .BCOUNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .fetch_read_i(fetch_read_i), .fetch_bcount_i(fetch_bcount_i), .fetch_addr_i(fetch_addr_i),
    .fetch_waitrequest_o(fetch_waitrequest_o), .fetch_rddata_o(fetch_rddata_o),
    .fetch_readdatavalid_o(fetch_readdatavalid_o),
    .update_wr_i(update_wr_i), .update_data_i(update_data_i), .update_be_i(update_be_i),
    .update_addr_i(update_addr_i), .update_wait_req_o(update_wait_req_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_bcount_o(mem_bcount_o), .mem_wrdata_o(mem_wrdata_o), .mem_be_o(mem_be_o),
    .mem_waitrequest_i(mem_waitrequest_i), .mem_rddata_i(mem_rddata_i),
    .mem_readdatavalid_i(mem_readdatavalid_i), .err_unexp_rdv_o(err_unexp_rdv_o)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] word_fn(input logic [31:0] base, input int idx);
    return (base + 32'(idx * 4)) ^ 32'h5A5A_0000;
  endfunction

  task automatic clear_inputs();
    fetch_read_i = 0; fetch_bcount_i = 0; fetch_addr_i = 0;
    update_wr_i = 0; update_data_i = 0; update_be_i = 0; update_addr_i = 0;
    mem_waitrequest_i = 0; mem_rddata_i = 0; mem_readdatavalid_i = 0;
  endtask

  task automatic apply_reset();
    reset = 1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (fetch_waitrequest_o !== 1'b1 || update_wait_req_o !== 1'b1) begin
      errors++; $display("FAIL reset_wait got %b%b exp 11", fetch_waitrequest_o, update_wait_req_o);
    end
    checks++;
    if ({mem_read_o, mem_write_o, fetch_readdatavalid_o, err_unexp_rdv_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000",
                         {mem_read_o, mem_write_o, fetch_readdatavalid_o, err_unexp_rdv_o});
    end
    checks++;
    if (mem_addr_o !== 0 || mem_bcount_o !== 0 || mem_wrdata_o !== 0 || mem_be_o !== 0) begin
      errors++; $display("FAIL reset_bus got %h %h %h %h exp 0", mem_addr_o, mem_bcount_o, mem_wrdata_o, mem_be_o);
    end
    reset = 0;
  endtask

  task automatic test_single_read();
    int got = 0;
    @(negedge clk);
    fetch_read_i = 1; fetch_addr_i = 32'h1000; fetch_bcount_i = 4'd8; mem_waitrequest_i = 0;
    #1;
    checks++;
    if (mem_read_o !== 1'b0 || fetch_waitrequest_o !== 1'b1) begin
      errors++; $display("FAIL rd_bubble got rd=%b wait=%b exp rd=0 wait=1", mem_read_o, fetch_waitrequest_o);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h1000 || mem_bcount_o !== 4'd8 ||
        mem_be_o !== 4'hF || fetch_waitrequest_o !== 1'b0) begin
      errors++; $display("FAIL rd_cmd got rd=%b addr=%h bc=%0d be=%h wait=%b exp 1 1000 8 f 0",
                         mem_read_o, mem_addr_o, mem_bcount_o, mem_be_o, fetch_waitrequest_o);
    end
    @(negedge clk);
    fetch_read_i = 0;
    for (int cyc = 0; cyc < 12 && got < 8; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_readdatavalid_i = (cyc != 3);
      mem_rddata_i = 32'hA0 + 32'(got);
      #1;
      checks++;
      if (mem_readdatavalid_i) begin
        if (fetch_readdatavalid_o !== 1'b1 || fetch_rddata_o !== 32'hA0 + 32'(got)) begin
          errors++; $display("FAIL rd_word%0d got v=%b d=%h exp v=1 d=%h", got,
                             fetch_readdatavalid_o, fetch_rddata_o, 32'hA0 + 32'(got));
        end
        got++;
      end else if (fetch_readdatavalid_o !== 1'b0 || mem_read_o !== 1'b0) begin
        errors++; $display("FAIL rd_gap got v=%b rd=%b exp 0 0", fetch_readdatavalid_o, mem_read_o);
      end
    end
    checks++;
    if (got != 8) begin errors++; $display("FAIL rd_count got %0d exp 8", got); end
    @(negedge clk);
    mem_readdatavalid_i = 0;
    update_wr_i = 1; update_addr_i = 32'h55; update_data_i = 32'h1; update_be_i = 4'hF;
    #1;
    checks++;
    if (mem_write_o !== 1'b0 || err_unexp_rdv_o !== 1'b0) begin
      errors++; $display("FAIL rd_end_idle got wr=%b err=%b exp 0 0", mem_write_o, err_unexp_rdv_o);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_write_o !== 1'b1) begin errors++; $display("FAIL rd_end_wr got %b exp 1", mem_write_o); end
    @(negedge clk);
    update_wr_i = 0;
  endtask

  task automatic test_write_stall();
    @(negedge clk);
    update_wr_i = 1; update_data_i = 32'hDEADBEEF; update_be_i = 4'h3; update_addr_i = 32'h2004;
    mem_waitrequest_i = 1;
    #1;
    checks++;
    if (mem_write_o !== 1'b0) begin errors++; $display("FAIL wr_bubble got %b exp 0", mem_write_o); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      mem_waitrequest_i = (k < 4);
      #1;
      checks++;
      if (mem_write_o !== 1'b1 || mem_wrdata_o !== 32'hDEADBEEF || mem_addr_o !== 32'h2004 ||
          mem_be_o !== 4'h3 || mem_bcount_o !== 4'd1) begin
        errors++; $display("FAIL wr_cmd%0d got wr=%b d=%h a=%h be=%h bc=%0d exp 1 deadbeef 2004 3 1", k,
                           mem_write_o, mem_wrdata_o, mem_addr_o, mem_be_o, mem_bcount_o);
      end
      checks++;
      if (update_wait_req_o !== (k < 4) || fetch_waitrequest_o !== 1'b1) begin
        errors++; $display("FAIL wr_wait%0d got %b fetch=%b exp %b fetch=1", k,
                           update_wait_req_o, fetch_waitrequest_o, (k < 4));
      end
    end
    @(negedge clk);
    update_wr_i = 0; mem_waitrequest_i = 0;
    #1;
    checks++;
    if (mem_write_o !== 1'b0) begin errors++; $display("FAIL wr_done got %b exp 0", mem_write_o); end
  endtask

  task automatic test_ordering();
    int got = 0;
    @(negedge clk);
    fetch_read_i = 1; fetch_addr_i = 32'h3000; fetch_bcount_i = 4'd4; mem_waitrequest_i = 0;
    @(negedge clk); #1;
    checks++;
    if (mem_read_o !== 1'b1) begin errors++; $display("FAIL ord_rd got %b exp 1", mem_read_o); end
    @(negedge clk);
    fetch_read_i = 0;
    update_wr_i = 1; update_addr_i = 32'h4000; update_data_i = 32'h1234_5678; update_be_i = 4'hF;
    for (int cyc = 0; cyc < 16 && got < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_readdatavalid_i = (cyc % 3 != 1);
      mem_rddata_i = $urandom;
      #1;
      checks++;
      if (mem_write_o !== 1'b0 || update_wait_req_o !== 1'b1) begin
        errors++; $display("FAIL ord_hold got wr=%b wait=%b exp 0 1", mem_write_o, update_wait_req_o);
      end
      if (mem_readdatavalid_i) got++;
    end
    @(negedge clk);
    mem_readdatavalid_i = 0;
    #1;
    checks++;
    if (mem_write_o !== 1'b0) begin errors++; $display("FAIL ord_bubble got %b exp 0", mem_write_o); end
    @(negedge clk); #1;
    checks++;
    if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h4000) begin
      errors++; $display("FAIL ord_wr got wr=%b a=%h exp 1 4000", mem_write_o, mem_addr_o);
    end
    @(negedge clk);
    update_wr_i = 0;
  endtask

  task automatic test_unexp_rdv();
    @(negedge clk);
    clear_inputs();
    mem_readdatavalid_i = 1; mem_rddata_i = $urandom;
    #1;
    checks++;
    if (fetch_readdatavalid_o !== 1'b0) begin
      errors++; $display("FAIL unexp_fwd got %b exp 0", fetch_readdatavalid_o);
    end
    @(negedge clk);
    mem_readdatavalid_i = 0;
    #1;
    checks++;
    if (err_unexp_rdv_o !== 1'b1) begin errors++; $display("FAIL unexp_flag got %b exp 1", err_unexp_rdv_o); end
    @(negedge clk); #1;
    checks++;
    if (err_unexp_rdv_o !== 1'b1) begin errors++; $display("FAIL unexp_sticky got %b exp 1", err_unexp_rdv_o); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    fetch_read_i = 1; fetch_addr_i = 32'h5000; fetch_bcount_i = 4'd8;
    @(negedge clk);
    @(negedge clk);
    fetch_read_i = 0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      mem_readdatavalid_i = 1; mem_rddata_i = 32'hB0 + 32'(i);
      #1;
      checks++;
      if (fetch_readdatavalid_o !== 1'b1 || fetch_rddata_o !== 32'hB0 + 32'(i)) begin
        errors++; $display("FAIL rst_word%0d got v=%b d=%h exp 1 %h", i, fetch_readdatavalid_o,
                           fetch_rddata_o, 32'hB0 + 32'(i));
      end
    end
    @(negedge clk);
    mem_readdatavalid_i = 0; reset = 1;
    @(negedge clk);
    reset = 0;
    update_wr_i = 1; update_addr_i = 32'h6000; update_data_i = 32'h77; update_be_i = 4'h1;
    #1;
    checks++;
    if (mem_read_o !== 1'b0 || fetch_waitrequest_o !== 1'b1 || err_unexp_rdv_o !== 1'b0 || mem_write_o !== 1'b0) begin
      errors++; $display("FAIL rst_idle got rd=%b fw=%b err=%b wr=%b exp 0 1 0 0",
                         mem_read_o, fetch_waitrequest_o, err_unexp_rdv_o, mem_write_o);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_write_o !== 1'b1) begin errors++; $display("FAIL rst_then_wr got %b exp 1", mem_write_o); end
    @(negedge clk);
    update_wr_i = 0;
    mem_readdatavalid_i = 1; mem_rddata_i = 32'hB2;
    #1;
    checks++;
    if (fetch_readdatavalid_o !== 1'b0) begin
      errors++; $display("FAIL rst_stale_fwd got %b exp 0", fetch_readdatavalid_o);
    end
    @(negedge clk);
    mem_readdatavalid_i = 0;
    #1;
    checks++;
    if (err_unexp_rdv_o !== 1'b1) begin errors++; $display("FAIL rst_stale_flag got %b exp 1", err_unexp_rdv_o); end
  endtask

  // Cycle-stepped two-master / one-memory environment; consumes rd_q and wr_q.
  task automatic run_engine(input int req_pct, input int stall_pct, input int gap_pct, input int max_cycles);
    bit          f_act = 0, u_act = 0, done = 0, busy;
    int          rd_out = 0, rd_idx = 0, cyc = 0;
    logic [31:0] rd_base = 0;
    logic [3:0]  exp_bc;
    grant_log.delete();
    while (!done && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      if (!f_act && rd_q.size() > 0 && $urandom_range(99) < req_pct) f_act = 1;
      if (!u_act && wr_q.size() > 0 && $urandom_range(99) < req_pct) u_act = 1;
      fetch_read_i = f_act;
      if (f_act) begin fetch_addr_i = rd_q[0].addr; fetch_bcount_i = rd_q[0].bcount; end
      else begin fetch_addr_i = $urandom; fetch_bcount_i = 4'($urandom); end
      update_wr_i = u_act;
      if (u_act) begin
        update_addr_i = wr_q[0].addr; update_data_i = wr_q[0].data; update_be_i = wr_q[0].be;
      end else begin
        update_addr_i = $urandom; update_data_i = $urandom; update_be_i = 4'($urandom);
      end
      mem_waitrequest_i   = ($urandom_range(99) < stall_pct);
      mem_readdatavalid_i = (rd_out > 0) && ($urandom_range(99) >= gap_pct);
      mem_rddata_i        = mem_readdatavalid_i ? word_fn(rd_base, rd_idx) : $urandom;
      #1;
      busy = (rd_out > 0);
      checks++;
      if (fetch_readdatavalid_o !== mem_readdatavalid_i ||
          (mem_readdatavalid_i && fetch_rddata_o !== word_fn(rd_base, rd_idx))) begin
        errors++; $display("FAIL fwd_data got v=%b d=%h exp v=%b d=%h", fetch_readdatavalid_o,
                           fetch_rddata_o, mem_readdatavalid_i, word_fn(rd_base, rd_idx));
      end
      if (mem_readdatavalid_i) begin rd_idx++; rd_out--; end
      checks++;
      if (mem_read_o === 1'b1 && mem_write_o === 1'b1) begin
        errors++; $display("FAIL both_cmds got rd=1 wr=1 exp at most one");
      end
      if (mem_read_o === 1'b1 && !mem_waitrequest_i) begin
        checks++;
        if (!f_act || busy) begin
          errors++; $display("FAIL rd_accept_illegal got f_act=%b busy=%b exp 1 0", f_act, busy);
        end else begin
          exp_bc = (rd_q[0].bcount == 0) ? 4'd1 : rd_q[0].bcount;
          if (mem_addr_o !== rd_q[0].addr || mem_bcount_o !== exp_bc || mem_be_o !== 4'hF ||
              fetch_waitrequest_o !== 1'b0) begin
            errors++; $display("FAIL rd_accept got a=%h bc=%0d be=%h w=%b exp a=%h bc=%0d be=f w=0",
                               mem_addr_o, mem_bcount_o, mem_be_o, fetch_waitrequest_o, rd_q[0].addr, exp_bc);
          end
          grant_log.push_back(1'b0);
          rd_out = int'(exp_bc); rd_idx = 0; rd_base = rd_q[0].addr;
          void'(rd_q.pop_front());
          f_act = 0;
        end
      end else begin
        checks++;
        if (fetch_waitrequest_o !== 1'b1) begin
          errors++; $display("FAIL fetch_wait_hold got %b exp 1", fetch_waitrequest_o);
        end
      end
      if (mem_write_o === 1'b1 && !mem_waitrequest_i) begin
        checks++;
        if (!u_act || busy) begin
          errors++; $display("FAIL wr_accept_illegal got u_act=%b busy=%b exp 1 0", u_act, busy);
        end else begin
          if (mem_addr_o !== wr_q[0].addr || mem_wrdata_o !== wr_q[0].data || mem_be_o !== wr_q[0].be ||
              mem_bcount_o !== 4'd1 || update_wait_req_o !== 1'b0) begin
            errors++; $display("FAIL wr_accept got a=%h d=%h be=%h bc=%0d w=%b exp a=%h d=%h be=%h bc=1 w=0",
                               mem_addr_o, mem_wrdata_o, mem_be_o, mem_bcount_o, update_wait_req_o,
                               wr_q[0].addr, wr_q[0].data, wr_q[0].be);
          end
          grant_log.push_back(1'b1);
          void'(wr_q.pop_front());
          u_act = 0;
        end
      end else begin
        checks++;
        if (update_wait_req_o !== 1'b1) begin
          errors++; $display("FAIL update_wait_hold got %b exp 1", update_wait_req_o);
        end
      end
      done = (rd_q.size() == 0) && (wr_q.size() == 0) && (rd_out == 0) && !f_act && !u_act;
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL engine_timeout got rd_left=%0d wr_left=%0d exp 0 0", rd_q.size(), wr_q.size());
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous();
    bit exp_log[$];
    int nw = 3, nr = 3;
    bit last_wr = 0, g;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back('{addr: 32'h7000 + 32'(i * 16), bcount: 4'd1});
      wr_q.push_back('{addr: 32'h8000 + 32'(i * 4), data: $urandom, be: 4'hF});
    end
    run_engine(100, 0, 0, 200);
    while (nw > 0 || nr > 0) begin
      if (nw > 0 && nr > 0) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
        g = 1;
`else
        g = !last_wr;
`endif
      end else begin
        g = (nw > 0);
      end
      exp_log.push_back(g);
      last_wr = g;
      if (g) nw--; else nr--;
    end
    checks++;
    if (grant_log.size() != exp_log.size()) begin
      errors++; $display("FAIL tie_count got %0d exp %0d", grant_log.size(), exp_log.size());
    end else begin
      for (int i = 0; i < exp_log.size(); i++) begin
        checks++;
        if (grant_log[i] !== exp_log[i]) begin
          errors++; $display("FAIL tie_grant%0d got %s exp %s", i, grant_log[i] ? "W" : "R", exp_log[i] ? "W" : "R");
        end
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    rd_q.push_back('{addr: 32'h9000, bcount: 4'd0});
    rd_q.push_back('{addr: 32'h9100, bcount: 4'd15});
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0) rd_q.push_back('{addr: $urandom & 32'hFFFF_FFFC, bcount: 4'($urandom)});
      else wr_q.push_back('{addr: $urandom & 32'hFFFF_FFFC, data: $urandom, be: 4'($urandom)});
    end
    run_engine(60, 30, 30, 20000);
    checks++;
    if (err_unexp_rdv_o !== 1'b0) begin errors++; $display("FAIL random_err got %b exp 0", err_unexp_rdv_o); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_stall();
    test_ordering();
    test_unexp_rdv();
    test_reset_mid_burst();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_desc_mem_arbiter.md
# dma_desc_mem_arbiter

Arbitrates the two descriptor-memory masters of the scatter-gather DMA onto one shared 32-bit AVMM master port:
- the descriptor fetch port (burst reads);
- the descriptor status-update port (single writes).

It sits directly downstream of `sg_dma`'s `dma_desc_fetch_*` and `dma_desc_update_*` ports, in front of the descriptor memory. Ordering is strict: a write is never issued while fetch read data is still outstanding. Read data is routed back to the fetch port.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all ports
- `BCOUNT_W`, 4, burst count width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `fetch_read_i`  in  1  fetch read request; held stable while `fetch_waitrequest_o`=1
- `fetch_bcount_i`  in  BCOUNT_W  burst length in words
- `fetch_addr_i`  in  ADDR_W  burst start address
- `fetch_waitrequest_o`  out  1  stall to fetch master
- `fetch_rddata_o`  out  32  read data to fetch master
- `fetch_readdatavalid_o`  out  1  read data valid to fetch master
- `update_wr_i`  in  1  update write request; held stable while `update_wait_req_o`=1
- `update_data_i`  in  32  write data
- `update_be_i`  in  4  byte enables
- `update_addr_i`  in  ADDR_W  write address
- `update_wait_req_o`  out  1  stall to update master
- `mem_read_o`  out  1  read command to memory
- `mem_write_o`  out  1  write command to memory
- `mem_addr_o`  out  ADDR_W  command address
- `mem_bcount_o`  out  BCOUNT_W  burst count (1 for writes)
- `mem_wrdata_o`  out  32  write data
- `mem_be_o`  out  4  byte enables (`4'hF` for reads)
- `mem_waitrequest_i`  in  1  memory stall
- `mem_rddata_i`  in  32  memory read data
- `mem_readdatavalid_i`  in  1  memory read data valid
- `err_unexp_rdv_o`  out  1  sticky flag: `readdatavalid` arrived with no burst outstanding

## Operation

States: `IDLE`, `RD_CMD`, `RD_DATA`, `WR_CMD`.

**IDLE**
- Samples the requests.
- Only `fetch_read_i` set → `RD_CMD`.
- Only `update_wr_i` set → `WR_CMD`.
- Both set → winner chosen by the arbitration policy (see Configuration).
- Registered flag `last_was_wr` records each grant.

**RD_CMD**
- `mem_read_o`=1.
- `mem_addr_o`/`mem_bcount_o` are muxed from the `fetch_*` inputs.
- `fetch_waitrequest_o` = `mem_waitrequest_i`.
- On acceptance (`mem_read_o` & !`mem_waitrequest_i`):
  - load `rd_remaining` with `fetch_bcount_i`;
  - a value of 0 is forced to 1 on `mem_bcount_o` and in the counter;
  - → `RD_DATA`.

**RD_DATA**
- No commands are issued.
- Each `mem_readdatavalid_i` is forwarded to `fetch_readdatavalid_o`/`fetch_rddata_o` and decrements `rd_remaining`.
- On the last word (`rd_remaining`==1 & valid) → `IDLE`.

**WR_CMD**
- `mem_write_o`=1; data, byte enables and address are muxed from the `update_*` inputs; `mem_bcount_o`=1.
- `update_wait_req_o` = `mem_waitrequest_i`.
- On acceptance → `IDLE`.

**Common rules**
- A non-granted requester sees its waitrequest held at 1.
- `mem_readdatavalid_i` outside `RD_DATA` is dropped (not forwarded) and sets `err_unexp_rdv_o`.
- `rd_remaining` is BCOUNT_W+1 bits wide, so a full burst of 2^BCOUNT_W is representable.

## Timing
Reset values:
- `fetch_waitrequest_o`=1, `update_wait_req_o`=1
- `mem_read_o`=0, `mem_write_o`=0, `fetch_readdatavalid_o`=0, `err_unexp_rdv_o`=0
- `mem_addr_o`/`mem_bcount_o`/`mem_wrdata_o`/`mem_be_o`=0
- state=`IDLE`, `rd_remaining`=0, `last_was_wr`=0

Latency and handshake:
- A request sampled in `IDLE` at edge N drives the memory command from cycle N+1.
- Best case: accepted in the same cycle, so a 1-cycle handshake with a 1-cycle arbitration bubble.
- Read-data path is combinational: memory valid → fetch valid with zero latency.
- Commands are held unchanged while `mem_waitrequest_i`=1.
- Requester waitrequest drops only in the acceptance cycle.

Boundary cases:
- Back-to-back: after a write is accepted, a pending read is granted earliest on the 2nd cycle after acceptance (one `IDLE` cycle).
- A requester deasserting before its grant is simply not served.
- Reset mid-burst: return to `IDLE` next cycle and clear the counter. Stale `readdatavalid` after reset is dropped and flagged.
- Final data word and a new request in the same cycle: the new request is sampled in `IDLE` the following cycle, not in the same cycle.

## Configuration
Macro: `DMA_ARB_FIXED_PRIO_EN`.
- **Defined:** on simultaneous requests in `IDLE`, the update write always wins. Status updates therefore complete before further fetches.
- **Undefined:** round-robin. Simultaneous requests go to the opposite of `last_was_wr`; after reset, the first tie goes to the write.

## Test plan
- **Single read burst:** `fetch_read_i`=1, `fetch_addr_i`=`0x1000`, `bcount`=8, memory returns 8 words `0xA0..0xA7` → one `mem_read_o` accept with `mem_bcount_o`=8; 8 forwarded valids in order; then `IDLE`.
- **Write with stall:** update writes `0xDEADBEEF`, `be`=`4'h3`, `addr`=`0x2004`, `mem_waitrequest_i` held high 3 cycles → `mem_write_o`, data and address stable for all 4 cycles; `update_wait_req_o` low only in cycle 4.
- **Ordering:** write request raised during `RD_DATA` of a 4-word burst → `mem_write_o` stays 0 until the 4th valid; write issued 2 cycles later.
- **Simultaneous requests, 3 rounds each:** round-robin build grants W,R,W,R,W,R; `DMA_ARB_FIXED_PRIO_EN` build grants W,W,W then R,R,R.
- **Error and reset:** valid pulse in `IDLE` → `err_unexp_rdv_o`=1 and no fetch valid. Reset asserted mid-burst after 2 of 8 words → next cycle `IDLE`, counter 0, flag 0, `fetch_waitrequest_o`=1.
